// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: bus owner encoding and mux selects.
package dmem_arb_pkg;
  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_e;

  localparam logic SEL_CPU = 1'b0;
  localparam logic SEL_DMA = 1'b1;
endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// DMA wait counter; raises force_gnt once the DMA has waited MAX_WAIT cycles.
module dmem_arb_starve_ctr #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dma_req,
  input  logic dma_gnt,
  output logic force_gnt
);
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [WW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (dma_req && !dma_gnt) begin
      if (wait_cnt != WW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign force_gnt = dma_req && (wait_cnt == WW'(MAX_WAIT));
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU MEM stage vs. DMA master, bounded DMA bursts.
// Define DMEM_ARB_STARVE_EN to add the DMA starvation guard.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 4,
  parameter int MAX_WAIT  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_last,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int BW = $clog2(BURST_MAX + 1);

  owner_e        owner, owner_nxt;
  logic [BW-1:0] beat, beat_nxt, beat_inc;
  logic          sel, cpu_acc, take, force_gnt;

  assign cpu_acc  = cpu_read | cpu_write;
  assign beat_inc = beat + 1'b1;

`ifdef DMEM_ARB_STARVE_EN
  dmem_arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk       (clk),
    .rst_n     (rst_n),
    .dma_req   (dma_req),
    .dma_gnt   (dma_gnt),
    .force_gnt (force_gnt)
  );
`else
  assign force_gnt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner      <= OWN_CPU;
      beat       <= '0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      owner      <= owner_nxt;
      beat       <= beat_nxt;
      dma_rvalid <= dma_gnt && !dma_we;
      if (dma_gnt && !dma_we) dma_rdata <= mem_rdata;
    end
  end

  always_comb begin
    take      = 1'b0;
    sel       = SEL_CPU;
    dma_gnt   = 1'b0;
    cpu_stall = 1'b0;
    owner_nxt = OWN_CPU;
    beat_nxt  = '0;
    case (owner)
      OWN_DMA: take = dma_req;
      default: take = dma_req && (!cpu_acc || force_gnt);
    endcase
    // beat is always 0 while the CPU owns the bus, so beat_inc starts a burst at 1
    if (take) begin
      sel       = SEL_DMA;
      dma_gnt   = 1'b1;
      cpu_stall = cpu_acc;
      if (!(dma_last || beat_inc == BW'(BURST_MAX))) begin
        owner_nxt = OWN_DMA;
        beat_nxt  = beat_inc;
      end
    end
    if (!rst_n) begin
      dma_gnt   = 1'b0;
      cpu_stall = 1'b0;
    end
  end

  assign mem_addr  = (sel == SEL_DMA) ? dma_addr  : cpu_addr;
  assign mem_wdata = (sel == SEL_DMA) ? dma_wdata : cpu_wdata;
  assign mem_read  = rst_n && ((sel == SEL_DMA) ? (dma_gnt && !dma_we) : (cpu_read  && !cpu_stall));
  assign mem_write = rst_n && ((sel == SEL_DMA) ? (dma_gnt &&  dma_we) : (cpu_write && !cpu_stall));
  assign cpu_rdata = mem_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: memory + reference model checked every cycle, plus directed literals.
module tb_dmem_arbiter;
  localparam int AW = 32, DW = 32, BM = 4, MW = 8;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic cpu_read, cpu_write, cpu_stall;
  logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata, dma_wdata, dma_rdata, mem_wdata, mem_rdata;
  logic dma_req, dma_we, dma_last, dma_gnt, dma_rvalid, mem_read, mem_write;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_last(dma_last), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  logic [DW-1:0] mem [0:255] = '{default: 32'h0};
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;

  int passed = 0, total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: who may use the bus this cycle, and what the memory holds.
  bit            m_own = 0, n_own = 0, m_rv = 0, n_rv = 0;
  int            m_beats = 0, n_beats = 0, m_wait = 0, n_wait = 0;
  logic [DW-1:0] m_rd = '0, n_rd = '0;
  logic [DW-1:0] ref_mem [0:255] = '{default: 32'h0};

  always @(negedge clk) begin : compare
    bit acc, take;
    int b;
    acc = cpu_read || cpu_write;
    chk("dma_rvalid", dma_rvalid, m_rv);
    chk("dma_rdata", dma_rdata, m_rd);
    if (!rst_n) begin
      chk("rst_gnt", dma_gnt, 0);
      chk("rst_stall", cpu_stall, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_mem_read", mem_read, 0);
      n_own = 0; n_beats = 0; n_wait = 0; n_rv = 0; n_rd = '0;
    end else begin
      take = dma_req && (m_own || !acc || (STARVE && m_wait >= MW));
      chk("dma_gnt", dma_gnt, take);
      chk("cpu_stall", cpu_stall, take && acc);
      n_rv = take && !dma_we;
      n_rd = m_rd;
      if (take) begin
        b       = m_beats + 1;
        n_own   = !(dma_last || b == BM);
        n_beats = n_own ? b : 0;
        n_wait  = 0;
        chk("dma_mem_addr", mem_addr, dma_addr);
        chk("dma_mem_read", mem_read, !dma_we);
        chk("dma_mem_write", mem_write, dma_we);
        if (dma_we) begin
          chk("dma_mem_wdata", mem_wdata, dma_wdata);
          ref_mem[dma_addr[7:0]] = dma_wdata;
        end else n_rd = ref_mem[dma_addr[7:0]];
      end else begin
        n_own = 0; n_beats = 0;
        n_wait = dma_req ? m_wait + 1 : 0;
        chk("cpu_mem_read", mem_read, cpu_read);
        chk("cpu_mem_write", mem_write, cpu_write);
        if (acc) chk("cpu_mem_addr", mem_addr, cpu_addr);
        if (cpu_read) chk("cpu_rdata", cpu_rdata, ref_mem[cpu_addr[7:0]]);
        if (cpu_write) begin
          chk("cpu_mem_wdata", mem_wdata, cpu_wdata);
          ref_mem[cpu_addr[7:0]] = cpu_wdata;
        end
      end
    end
  end

  always @(posedge clk) begin
    m_own <= n_own; m_beats <= n_beats; m_wait <= n_wait; m_rv <= n_rv; m_rd <= n_rd;
  end

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cwd,
                       input logic dr, input logic dwe, input logic dl,
                       input logic [31:0] da, input logic [31:0] dwd);
    cpu_read = cr; cpu_write = cw; cpu_addr = ca; cpu_wdata = cwd;
    dma_req = dr; dma_we = dwe; dma_last = dl; dma_addr = da; dma_wdata = dwd;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] exp3;
    int k;
    rst_n = 1'b0;
    cpu_read = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_last = 0; dma_addr = 0; dma_wdata = 0;
    tick(); tick();
    rst_n = 1'b1;

    // reset then idle
    idle();
    chk("t1_gnt", dma_gnt, 0);
    chk("t1_stall", cpu_stall, 0);
    chk("t1_rvalid", dma_rvalid, 0);
    chk("t1_strobes", {mem_read, mem_write}, 2'b00);
    tick();

    // CPU write, then DMA reads it back
    drive(0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    chk("t2_cpu_wr", mem_write, 1);
    tick();
    drive(0, 0, 0, 0, 1, 0, 1, 32'h10, 0);
    chk("t2_gnt", dma_gnt, 1);
    chk("t2_rd_strobe", mem_read, 1);
    tick();
    idle();
    chk("t2_rvalid", dma_rvalid, 1);
    chk("t2_rdata", dma_rdata, 32'hDEADBEEF);
    tick();
    idle();
    chk("t2_rvalid_drop", dma_rvalid, 0);
    chk("t2_rdata_hold", dma_rdata, 32'hDEADBEEF);
    tick();

    // 6-beat write burst, BURST_MAX=4; CPU takes cycle 4
    exp3 = 7'b1101111;
    k = 0;
    for (int c = 0; c < 7; c++) begin
      drive(c == 4, 0, 32'h41, 0, 1, 1, k == 5, 32'h40 + k, 32'h1000 + k);
      chk("t3_gnt", dma_gnt, exp3[c]);
      if (c == 4) chk("t3_cpu_rdata", cpu_rdata, 32'h1001);
      if (exp3[c]) k++;
      tick();
    end
    drive(1, 0, 32'h45, 0, 0, 0, 0, 0, 0);
    chk("t3_last_beat", cpu_rdata, 32'h1005);
    tick();

    // CPU read of 0x20 stalled by a 3-beat DMA read burst
    drive(0, 1, 32'h20, 32'h55AA, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0, 32'h40, 0);
    chk("t4_gnt0", dma_gnt, 1);
    tick();
    drive(1, 0, 32'h20, 0, 1, 0, 0, 32'h41, 0);
    chk("t4_stall1", cpu_stall, 1);
    chk("t4_rdata0", dma_rdata, 32'h1000);
    tick();
    drive(1, 0, 32'h20, 0, 1, 0, 1, 32'h42, 0);
    chk("t4_stall2", cpu_stall, 1);
    chk("t4_gnt2", dma_gnt, 1);
    tick();
    drive(1, 0, 32'h20, 0, 0, 0, 0, 0, 0);
    chk("t4_unstall", cpu_stall, 0);
    chk("t4_cpu_rdata", cpu_rdata, 32'h55AA);
    chk("t4_rdata2", dma_rdata, 32'h1002);
    tick();

    // CPU busy every cycle while DMA holds its request
    for (int c = 0; c < (STARVE ? 9 : 12); c++) begin
      drive(1, 0, 32'h20, 0, 1, 1, 1, 32'h60, 32'hBEEF0000 + c);
      chk("t5_gnt", dma_gnt, STARVE && c == 8);
      chk("t5_stall", cpu_stall, STARVE && c == 8);
      tick();
    end
    drive(0, 0, 0, 0, 1, 1, 1, 32'h61, 32'h77);
    chk("t5_idle_gnt", dma_gnt, 1);
    tick();

    // reset during the 2nd beat of a DMA write burst
    drive(0, 0, 0, 0, 1, 1, 0, 32'h80, 32'hA0);
    chk("t6_beat0", dma_gnt, 1);
    tick();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 1, 1, 0, 32'h81, 32'hA1);
    chk("t6_no_write", mem_write, 0);
    chk("t6_no_gnt", dma_gnt, 0);
    tick();
    rst_n = 1'b1;
    drive(1, 0, 32'h81, 0, 1, 1, 0, 32'h82, 32'hA2);
    chk("t6_cpu_owner", dma_gnt, 0);
    chk("t6_stall", cpu_stall, 0);
    chk("t6_unwritten", cpu_rdata, 32'h0);
    tick();
    idle();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
